change_gen: RTL and testbench
=============================

CHANGE_GEN -- requirements
Module: change_gen

Interface
REQ-001 Parameter N, default 3: number of condition channels; legal N >= 2.
REQ-002 Parameter DIV, default 1: enabled cycles per R toggle; legal DIV >= 1.
REQ-003 Parameter STABLE, default 2: consecutive matching edges required before enable; legal STABLE >= 0.
REQ-004 Parameter CW, default 8: width of pause_cnt; legal CW >= 1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 C  input  N  condition channels, sampled each rising clk edge.
REQ-008 R  output  1  gated divided-clock output, registered.
REQ-009 active  output  1  registered copy of internal enable.
REQ-010 pause_cnt  output  CW  count of enable 1->0 transitions, saturating.

Function
REQ-011 match SHALL be 1 when all N bits of C are equal (all 0 or all 1), else 0.
REQ-012 stab_cnt SHALL clear to 0 on any edge with match=0, increment on edges with match=1, and saturate at STABLE.
REQ-013 Combinational enable SHALL equal match AND (stab_cnt >= STABLE); with STABLE=0, enable = match.
REQ-014 On an edge with enable=1: if div_cnt == DIV-1, R SHALL invert and div_cnt SHALL clear to 0; otherwise div_cnt SHALL increment and R SHALL hold.
REQ-015 On an edge with enable=0, R and div_cnt SHALL hold (pause); phase resumes from held div_cnt on re-enable.
REQ-016 While continuously enabled, R SHALL have a period of 2*DIV clk cycles; DIV=1 gives clk/2.
REQ-017 active SHALL be loaded with enable on every non-reset edge (one-cycle latency).
REQ-018 pause_cnt SHALL increment by 1 on an edge where active=1 and enable=0, saturating at 2^CW-1 with no wrap.
REQ-019 A single mismatching sample SHALL clear stab_cnt; re-enable SHALL then need full STABLE requalification.
REQ-020 The block SHALL contain no combinational path from C to any output.

Reset
REQ-021 With reset=1 at a rising edge: R=0, active=0, pause_cnt=0, stab_cnt=0, div_cnt=0.
REQ-022 Reset SHALL take priority over all other updates, including mid-toggle and mid-qualification.
REQ-023 A reset edge SHALL NOT count as a pause event.

Configuration
REQ-024 Macro CHANGE_GEN_PAUSE_CNT_EN: when defined, pause counting SHALL be implemented per REQ-018.
REQ-025 When CHANGE_GEN_PAUSE_CNT_EN is undefined, the pause counter SHALL be omitted, pause_cnt SHALL be constant 0, and all other behaviour SHALL be unchanged.

Verification (N=3, DIV=2, STABLE=2, CW=8, macro defined unless stated)
REQ-026 reset=1 for 3 edges, C=3'b111 -> R=0, active=0, pause_cnt=0 after each reset edge.
REQ-027 Release reset, C=3'b000 held -> enable after edge 2, active=1 after edge 3, R rises at edge 4 and toggles at edges 6, 8, 10.
REQ-028 Running, then C=3'b101 for 3 edges, then 3'b111 -> R and div_cnt frozen, active=0 one edge later, pause_cnt=1, R resumes toggling only after 2 requalifying edges with phase continued.
REQ-029 C sequence 3'b011, 3'b111, 3'b010 repeated 10 times after reset -> enable never asserts, R=0, pause_cnt=0.
REQ-030 CW=2, 5 qualified-run/pause cycles -> pause_cnt 1,2,3,3,3; macro undefined -> pause_cnt stays 0.
REQ-031 reset=1 for one edge while R=1 and div_cnt=1 -> R=0, div_cnt=0, active=0 next edge; with C held at 3'b111, R next rises 4 edges after reset release.

Source files
------------

// File: rtl/change_gen.sv
// change_gen: gated divide-by-2*DIV clock generator that runs while all condition channels agree.
// Optional pause counter is built only when CHANGE_GEN_PAUSE_CNT_EN is defined.
module change_gen #(
    parameter int N      = 3,
    parameter int DIV    = 1,
    parameter int STABLE = 2,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  C,
    output logic          R,
    output logic          active,
    output logic [CW-1:0] pause_cnt
);

    localparam int SW = (STABLE < 1) ? 1 : $clog2(STABLE + 1);
    localparam int DW = (DIV < 2) ? 1 : $clog2(DIV);

    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic          match;
    logic          qualified;
    logic          enable;
    logic [SW-1:0] stab_cnt;
    logic [DW-1:0] div_cnt;

    assign match = (&C) | ~(|C);

    // stab_cnt saturates at STABLE, so equality is the same as >=
    assign qualified = (stab_cnt == STAB_MAX);
    assign enable    = match & qualified;

    always_ff @(posedge clk) begin
        if (reset) begin
            stab_cnt <= '0;
        end else if (!match) begin
            stab_cnt <= '0;
        end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Divider freezes while disabled so the phase resumes where it stopped
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            R       <= 1'b0;
        end else if (enable) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                R       <= ~R;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
        end else begin
            active <= enable;
        end
    end

`ifdef CHANGE_GEN_PAUSE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pause_cnt <= '0;
        end else if (active && !enable && (pause_cnt != {CW{1'b1}})) begin
            pause_cnt <= pause_cnt + 1'b1;
        end
    end
`else
    assign pause_cnt = '0;
`endif

endmodule

// File: tb/tb_change_gen.sv
// Directed-vector bench for change_gen (main: N=3 DIV=2 STABLE=2 CW=8;
// second instance: N=2 DIV=1 STABLE=0 CW=2 for saturation and edge parameters).
module tb_change_gen;

`ifdef CHANGE_GEN_PAUSE_CNT_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] c;
    logic       r;
    logic       act;
    logic [7:0] pcnt;

    logic       reset2;
    logic [1:0] c2;
    logic       r2;
    logic       act2;
    logic [1:0] pcnt2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    change_gen #(.N(3), .DIV(2), .STABLE(2), .CW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .C         (c),
        .R         (r),
        .active    (act),
        .pause_cnt (pcnt)
    );

    change_gen #(.N(2), .DIV(1), .STABLE(0), .CW(2)) dut2 (
        .clk       (clk),
        .reset     (reset2),
        .C         (c2),
        .R         (r2),
        .active    (act2),
        .pause_cnt (pcnt2)
    );

    typedef struct {
        logic       rst;
        logic [2:0] c;
        logic       r;
        logic       act;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic [2:0] cv, logic rv,
                                logic av, logic [7:0] pv);
        vec_t v;
        v.rst = rst;
        v.c   = cv;
        v.r   = rv;
        v.act = av;
        v.p   = PEN ? pv : 8'd0;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int idx, logic [31:0] got,
                         logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s step %0d: got %0d, expected %0d",
                     name, idx, got, exp);
        end
    endtask

    task automatic step1(logic rst, logic [2:0] cv);
        reset = rst;
        c     = cv;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(logic rst, logic [1:0] cv);
        reset2 = rst;
        c2     = cv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] pat [3];
        logic [1:0] exp_sat [5];

        pat[0] = 3'b011;
        pat[1] = 3'b111;
        pat[2] = 3'b010;
        exp_sat[0] = 2'd1;
        exp_sat[1] = 2'd2;
        exp_sat[2] = 2'd3;
        exp_sat[3] = 2'd3;
        exp_sat[4] = 2'd3;

        // reset held with matching input
        add(1, 3'b111, 0, 0, 0);
        add(1, 3'b111, 0, 0, 0);
        add(1, 3'b111, 0, 0, 0);
        // qualification then running toggles
        add(0, 3'b000, 0, 0, 0);
        add(0, 3'b000, 0, 0, 0);
        add(0, 3'b000, 0, 1, 0);
        add(0, 3'b000, 1, 1, 0);
        add(0, 3'b000, 1, 1, 0);
        add(0, 3'b000, 0, 1, 0);
        add(0, 3'b000, 0, 1, 0);
        add(0, 3'b000, 1, 1, 0);
        add(0, 3'b000, 1, 1, 0);
        // pause: R and phase frozen, one pause event
        add(0, 3'b101, 1, 0, 1);
        add(0, 3'b101, 1, 0, 1);
        add(0, 3'b101, 1, 0, 1);
        // requalify, phase continues from div_cnt=1
        add(0, 3'b111, 1, 0, 1);
        add(0, 3'b111, 1, 0, 1);
        add(0, 3'b111, 0, 1, 1);
        add(0, 3'b111, 0, 1, 1);
        add(0, 3'b111, 1, 1, 1);
        // reset while active with mismatch must not count a pause
        add(1, 3'b101, 0, 0, 0);
        // never stable long enough to enable
        for (int i = 0; i < 30; i++) begin
            add(0, pat[i % 3], 0, 0, 0);
        end

        reset  = 1'b1;
        c      = 3'b111;
        reset2 = 1'b1;
        c2     = 2'b00;
        @(negedge clk);

        foreach (vecs[i]) begin
            step1(vecs[i].rst, vecs[i].c);
            check("R", i, 32'(r), 32'(vecs[i].r));
            check("active", i, 32'(act), 32'(vecs[i].act));
            check("pause_cnt", i, 32'(pcnt), 32'(vecs[i].p));
        end

        // reset mid-toggle: reach R=1, div_cnt=1
        step1(1, 3'b111);
        step1(0, 3'b111);
        step1(0, 3'b111);
        step1(0, 3'b111);
        step1(0, 3'b111);
        step1(0, 3'b111);
        check("mid_R_pre", 0, 32'(r), 32'd1);
        step1(1, 3'b111);
        check("mid_R_rst", 0, 32'(r), 32'd0);
        check("mid_act_rst", 0, 32'(act), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step1(0, 3'b111);
            check("mid_R_rel", k, 32'(r), (k == 4) ? 32'd1 : 32'd0);
            check("mid_act_rel", k, 32'(act), (k >= 3) ? 32'd1 : 32'd0);
        end

        // CW=2 saturation, DIV=1, STABLE=0, N=2
        step2(1, 2'b00);
        step2(0, 2'b00);
        check("s0_R", 0, 32'(r2), 32'd1);
        check("s0_act", 0, 32'(act2), 32'd1);
        step2(0, 2'b01);
        check("s0_R_hold", 0, 32'(r2), 32'd1);
        step2(1, 2'b00);
        for (int k = 0; k < 5; k++) begin
            step2(0, 2'b11);
            check("sat_R_a", k, 32'(r2), 32'd1);
            step2(0, 2'b11);
            check("sat_R_b", k, 32'(r2), 32'd0);
            step2(0, 2'b01);
            check("sat_act", k, 32'(act2), 32'd0);
            check("sat_pause", k, 32'(pcnt2),
                  PEN ? 32'(exp_sat[k]) : 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
